trapez_shaper_cfg: RTL and testbench
====================================

TRAPEZ_SHAPER_CFG -- requirements
Module: trapez_shaper_cfg

Interface
REQ-001 Parameter CHANNEL_SIZE, default 2, number of parallel shaper channels.
REQ-002 Parameter SIZE_DATA, default 16, signed sample width per channel.
REQ-003 Parameter MAX_DEPTH, default 300, delay-line depth per channel in samples.
REQ-004 Parameter SIZE_CONSTANT, default 8, width of cfg_k and cfg_l.
REQ-005 Parameter SIZE_ADD_CAPACITY, default 9, accumulator guard bits.
REQ-006 Parameters DEFAULT_K 25, DEFAULT_L 20, DEFAULT_NORM 10, the configuration loaded at reset.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 reset_n  input  1  reset; asynchronous and active-low.
REQ-009 input_data  input  CHANNEL_SIZE*SIZE_DATA  signed samples, channel 0 in the LSBs.
REQ-010 input_data_valid  input  1  one sample per channel this cycle.
REQ-011 cfg_k / cfg_l  input  SIZE_CONSTANT each  rise time k and flat-top l, in samples.
REQ-012 cfg_norm  input  5  output right-shift amount.
REQ-013 cfg_apply  input  1  one-cycle request to load cfg_k, cfg_l and cfg_norm.
REQ-014 cfg_ready  output  1  high in RUN; cfg_apply is accepted only when it is high.
REQ-015 cfg_error  output  1  one-cycle pulse when a configuration is rejected.
REQ-016 output_data  output  CHANNEL_SIZE*SIZE_DATA  normalised, saturated trapezoid samples.
REQ-017 output_data_valid  output  1  output_data is valid this cycle.
REQ-018 output_overflow  output  CHANNEL_SIZE  per-channel saturation flag, qualified by output_data_valid.

Function
REQ-019 Each channel computes acc(n) = acc(n-1) + x(n) - x(n-k) - x(n-k-l) + x(n-2k-l), advancing only on input_data_valid.
REQ-020 acc is signed, SIZE_DATA+SIZE_ADD_CAPACITY bits wide; it wraps two's-complement and is never saturated internally.
REQ-021 output = acc >>> norm (arithmetic shift), clamped to [-2^(SIZE_DATA-1), 2^(SIZE_DATA-1)-1]; overflow bit = 1 when clamping occurs.
REQ-022 Output is registered: output_data_valid follows the accepted input_data_valid by exactly 1 cycle, and only in RUN.
REQ-023 Delay line is a per-channel circular buffer of MAX_DEPTH entries with a shared write pointer that wraps from MAX_DEPTH-1 to 0.
REQ-024 A fill counter saturates at 2k+l; any tap x(n-d) with d > fill count reads as 0, so the buffer is never bulk-cleared.
REQ-025 States: FLUSH and RUN.
  - FLUSH: cfg_ready=0, output_data_valid=0.
  - FLUSH -> RUN once 2k+l valid samples have been accepted since entry.
REQ-026 RUN -> FLUSH on an accepted cfg_apply.
  - On entry: load new k, l, norm; clear acc, fill counter and flush counter.
REQ-027 cfg_apply is rejected, with a cfg_error pulse and no change to state or configuration, when any of these hold:
  - k = 0;
  - 2k+l > MAX_DEPTH;
  - norm > SIZE_DATA+SIZE_ADD_CAPACITY-1.
REQ-028 cfg_apply while cfg_ready=0 is ignored: no error pulse, no effect.
REQ-029 cfg_apply and input_data_valid in the same RUN cycle: the configuration takes priority and that sample is discarded, with no output produced.
REQ-030 l = 0 is legal and produces a triangle.
REQ-031 Input samples continue to be accepted and shifted in during FLUSH.

Reset
REQ-032 On reset_n low the block SHALL:
  - enter FLUSH;
  - set k/l/norm = DEFAULT_K/DEFAULT_L/DEFAULT_NORM;
  - clear acc, fill counter, flush counter and write pointer;
  - drive output_data=0, output_data_valid=0, output_overflow=0, cfg_ready=0, cfg_error=0.
REQ-033 Reset asserted mid-operation SHALL abort any flush or step in progress immediately.
  - After release, behaviour is identical to that after power-up reset.

Verification
REQ-034 After reset, feed 70 zero samples -> no valid output during them; cfg_ready rises after the 70th; the next sample yields output 0, valid 1 cycle later.
REQ-035 Apply k=4, l=2, norm=2; feed 10 zeros, then a step of 1000 on channel 0 and -1000 on channel 1.
  - Channel 0 outputs 250, 500, 750, 1000, 1000, 1000, 750, 500, 250, 0, then stays 0.
  - Channel 1 outputs the negated sequence.
REQ-036 With k=4, l=2, norm=0, step of 20000 -> output clamps at 32767 with output_overflow[0]=1; output returns to 0 after the trailing edge.
REQ-037 cfg_apply with k=200, l=0 (2k+l=400 > 300) -> single-cycle cfg_error; cfg_ready stays 1; the step response is unchanged from the previous configuration.
REQ-038 cfg_apply coincident with input_data_valid in RUN -> no output for that sample; FLUSH lasts exactly 2k+l further valid samples.
REQ-039 reset_n pulsed low mid-step -> all outputs 0 asynchronously; block resumes in FLUSH with defaults k=25, l=20, norm=10.

Source files
------------

// File: rtl/trapez_shaper_cfg_if.sv
// -----------------------------------------------------------------------------
// trapez_shaper_cfg_if
// Sample stream and configuration bus of the trapezoidal shaper.
//   input_data / input_data_valid    : packed signed samples, channel 0 in LSBs
//   cfg_k / cfg_l / cfg_norm         : rise time, flat top, output right-shift
//   cfg_apply                        : one-cycle request to load the config
//   cfg_ready / cfg_error            : config accepted when ready; reject pulse
//   output_data / output_data_valid  : normalised, saturated trapezoid samples
//   output_overflow                  : per-channel clamp flag
// master = sample/config source, slave = shaper.
// -----------------------------------------------------------------------------
interface trapez_shaper_cfg_if #(
    parameter int CHANNEL_SIZE  = 2,
    parameter int SIZE_DATA     = 16,
    parameter int SIZE_CONSTANT = 8
);
    logic [CHANNEL_SIZE*SIZE_DATA-1:0] input_data;
    logic                              input_data_valid;
    logic [SIZE_CONSTANT-1:0]          cfg_k;
    logic [SIZE_CONSTANT-1:0]          cfg_l;
    logic [4:0]                        cfg_norm;
    logic                              cfg_apply;
    logic                              cfg_ready;
    logic                              cfg_error;
    logic [CHANNEL_SIZE*SIZE_DATA-1:0] output_data;
    logic                              output_data_valid;
    logic [CHANNEL_SIZE-1:0]           output_overflow;

    modport master (
        output input_data, input_data_valid, cfg_k, cfg_l, cfg_norm, cfg_apply,
        input  cfg_ready, cfg_error, output_data, output_data_valid, output_overflow
    );

    modport slave (
        input  input_data, input_data_valid, cfg_k, cfg_l, cfg_norm, cfg_apply,
        output cfg_ready, cfg_error, output_data, output_data_valid, output_overflow
    );
endinterface

// File: rtl/trapez_shaper_cfg.sv
// -----------------------------------------------------------------------------
// trapez_shaper_cfg
// Multi-channel trapezoidal pulse shaper with run-time k/l/norm configuration.
//   clk      : sole clock, rising edge
//   reset_n  : asynchronous, active-low reset
//   bus      : trapez_shaper_cfg_if.slave (samples in, config, shaped samples out)
// Per channel: acc(n) = acc(n-1) + x(n) - x(n-k) - x(n-k-l) + x(n-2k-l),
// output = clamp(acc >>> norm). A new configuration puts the block in FLUSH
// until 2k+l fresh samples have been accepted.
// -----------------------------------------------------------------------------
module trapez_shaper_cfg #(
    parameter int CHANNEL_SIZE      = 2,
    parameter int SIZE_DATA         = 16,
    parameter int MAX_DEPTH         = 300,
    parameter int SIZE_CONSTANT     = 8,
    parameter int SIZE_ADD_CAPACITY = 9,
    parameter int DEFAULT_K         = 25,
    parameter int DEFAULT_L         = 20,
    parameter int DEFAULT_NORM      = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    trapez_shaper_cfg_if.slave bus
);
    localparam int AW    = SIZE_DATA + SIZE_ADD_CAPACITY;
    localparam int PTR_W = $clog2(MAX_DEPTH);
    localparam int D_W   = $clog2(MAX_DEPTH + 1);
    localparam int CW    = (D_W > SIZE_CONSTANT + 2) ? D_W : SIZE_CONSTANT + 2;
    localparam int AD    = ((CW > PTR_W) ? CW : PTR_W) + 1;
    localparam logic signed [AW-1:0] MAX_OUT = AW'((2 ** (SIZE_DATA - 1)) - 1);
    localparam logic signed [AW-1:0] MIN_OUT = AW'(-(2 ** (SIZE_DATA - 1)));

    typedef enum logic {FLUSH, RUN} state_t;

    state_t                   state, state_next;
    logic [SIZE_CONSTANT-1:0] k_q, l_q;
    logic [4:0]               norm_q;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CW-1:0]            fill, flush_cnt;
    logic [CW-1:0]            dist_k, dist_kl, span, new_span;
    logic [PTR_W-1:0]         addr_k, addr_kl, addr_2kl;
    logic                     en_k, en_kl, en_2kl;
    logic                     cfg_ok, cfg_accept, cfg_reject, take, emit;
    logic                     err_q, valid_q;
    logic [CHANNEL_SIZE*SIZE_DATA-1:0] out_data;
    logic [CHANNEL_SIZE-1:0]           out_ovf;

    // Circular-buffer address d samples behind the write pointer.
    function automatic logic [PTR_W-1:0] tap_addr(input logic [PTR_W-1:0] ptr,
                                                  input logic [CW-1:0]    d);
        logic [AD-1:0] p, dd, r;
        p  = AD'(ptr);
        dd = AD'(d);
        r  = (p >= dd) ? p - dd : p + AD'(MAX_DEPTH) - dd;
        return r[PTR_W-1:0];
    endfunction

    assign dist_k   = CW'(k_q);
    assign dist_kl  = CW'(k_q) + CW'(l_q);
    assign span     = (CW'(k_q) << 1) + CW'(l_q);
    assign new_span = (CW'(bus.cfg_k) << 1) + CW'(bus.cfg_l);

    assign addr_k   = tap_addr(wr_ptr, dist_k);
    assign addr_kl  = tap_addr(wr_ptr, dist_kl);
    assign addr_2kl = tap_addr(wr_ptr, span);

    // Taps older than the samples seen since the last flush read as zero,
    // so stale buffer contents never need clearing.
    assign en_k   = (dist_k  <= fill);
    assign en_kl  = (dist_kl <= fill);
    assign en_2kl = (span    <= fill);

    assign cfg_ok = (bus.cfg_k != '0) && (new_span <= CW'(MAX_DEPTH)) &&
                    (bus.cfg_norm <= 5'(AW - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FLUSH;
        else          state <= state_next;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cfg_accept = 1'b0;
        cfg_reject = 1'b0;
        if (state == RUN && bus.cfg_apply) begin
            cfg_accept = cfg_ok;
            cfg_reject = !cfg_ok;
        end
        // An accepted configuration wins over a coincident sample.
        take = bus.input_data_valid && !cfg_accept;
        emit = take && (state == RUN);
        case (state)
            FLUSH: if (take && (flush_cnt + CW'(1)) == span) state_next = RUN;
            RUN:   if (cfg_accept) state_next = FLUSH;
            default: state_next = FLUSH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q       <= SIZE_CONSTANT'(DEFAULT_K);
            l_q       <= SIZE_CONSTANT'(DEFAULT_L);
            norm_q    <= 5'(DEFAULT_NORM);
            wr_ptr    <= '0;
            fill      <= '0;
            flush_cnt <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            err_q   <= cfg_reject;
            valid_q <= emit;
            if (cfg_accept) begin
                k_q       <= bus.cfg_k;
                l_q       <= bus.cfg_l;
                norm_q    <= bus.cfg_norm;
                fill      <= '0;
                flush_cnt <= '0;
            end else if (take) begin
                wr_ptr <= (wr_ptr == PTR_W'(MAX_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                if (fill < span)     fill      <= fill + CW'(1);
                if (state == FLUSH)  flush_cnt <= flush_cnt + CW'(1);
            end
        end
    end

    for (genvar c = 0; c < CHANNEL_SIZE; c++) begin : g_ch
        logic signed [SIZE_DATA-1:0] mem [MAX_DEPTH];
        logic signed [SIZE_DATA-1:0] x, x_k, x_kl, x_2kl, out_c, out_q;
        logic signed [AW-1:0]        acc, acc_next, shifted;
        logic                        ovf_c, ovf_q;

        assign x     = bus.input_data[c*SIZE_DATA +: SIZE_DATA];
        assign x_k   = en_k   ? mem[addr_k]   : '0;
        assign x_kl  = en_kl  ? mem[addr_kl]  : '0;
        assign x_2kl = en_2kl ? mem[addr_2kl] : '0;

        // Wraps modulo 2^AW by design; the guard bits keep it exact in use.
        assign acc_next = acc + AW'(x) - AW'(x_k) - AW'(x_kl) + AW'(x_2kl);
        assign shifted  = acc_next >>> norm_q;

        always_comb begin
            out_c = shifted[SIZE_DATA-1:0];
            ovf_c = 1'b0;
            if (shifted > MAX_OUT) begin
                out_c = MAX_OUT[SIZE_DATA-1:0];
                ovf_c = 1'b1;
            end else if (shifted < MIN_OUT) begin
                out_c = MIN_OUT[SIZE_DATA-1:0];
                ovf_c = 1'b1;
            end
        end

        // NOTE: the delay line has no reset; the fill counter masks unwritten entries.
        always_ff @(posedge clk) begin
            if (take) mem[wr_ptr] <= x;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc   <= '0;
                out_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (cfg_accept) acc <= '0;
                else if (take)  acc <= acc_next;
                if (emit) begin
                    out_q <= out_c;
                    ovf_q <= ovf_c;
                end
            end
        end

        assign out_data[c*SIZE_DATA +: SIZE_DATA] = out_q;
        assign out_ovf[c]                         = ovf_q;
    end

    assign bus.cfg_ready         = (state == RUN);
    assign bus.cfg_error         = err_q;
    assign bus.output_data       = out_data;
    assign bus.output_data_valid = valid_q;
    assign bus.output_overflow   = out_ovf;
endmodule

// File: tb/tb_trapez_shaper_cfg.sv
// -----------------------------------------------------------------------------
// tb_trapez_shaper_cfg
// Self-checking bench for trapez_shaper_cfg. The reference keeps the samples
// accepted since the last configuration and evaluates the trapezoid directly
// as sum(x[n-i], i<k) - sum(x[n-i], k+l<=i<2k+l), then shifts and clamps.
// -----------------------------------------------------------------------------
module tb_trapez_shaper_cfg;
    localparam int CH  = 2;
    localparam int SD  = 16;
    localparam int MD  = 300;
    localparam int AW  = 25;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    trapez_shaper_cfg_if #(.CHANNEL_SIZE(CH), .SIZE_DATA(SD), .SIZE_CONSTANT(8)) bus ();

    trapez_shaper_cfg #(
        .CHANNEL_SIZE(CH), .SIZE_DATA(SD), .MAX_DEPTH(MD), .SIZE_CONSTANT(8),
        .SIZE_ADD_CAPACITY(9), .DEFAULT_K(25), .DEFAULT_L(20), .DEFAULT_NORM(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    bit m_run;
    int m_k, m_l, m_norm, m_flush;
    int hist0[$];
    int hist1[$];
    int last0, last1;

    int step035[14] = '{250, 500, 750, 1000, 1000, 1000, 750, 500, 250, 0, 0, 0, 0, 0};

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_k = 25; m_l = 20; m_norm = 10; m_flush = 0;
        hist0.delete();
        hist1.delete();
    endtask

    function automatic int hval(input int ch, input int i);
        if (ch == 0) return (i < hist0.size()) ? hist0[i] : 0;
        return (i < hist1.size()) ? hist1[i] : 0;
    endfunction

    function automatic void model_out(input int ch, output int y, output bit ovf);
        int acc = 0;
        for (int i = 0; i < m_k; i++) acc += hval(ch, i);
        for (int i = m_k + m_l; i < 2*m_k + m_l; i++) acc -= hval(ch, i);
        acc = (acc <<< (32 - AW)) >>> (32 - AW);
        y = acc >>> m_norm;
        ovf = 1'b0;
        if (y > 32767)  begin y = 32767;  ovf = 1'b1; end
        if (y < -32768) begin y = -32768; ovf = 1'b1; end
    endfunction

    // Drive one clock cycle of stimulus, advance the reference, check results.
    task automatic cycle(input bit valid, input int d0, input int d1,
                         input bit apply, input int k, input int l, input int norm);
        bit ok, accept, exp_err, take, emit;
        int y0, y1;
        bit o0, o1;
        y0 = 0; y1 = 0; o0 = 0; o1 = 0;
        bus.input_data_valid = valid;
        bus.input_data       = {SD'(d1), SD'(d0)};
        bus.cfg_apply        = apply;
        bus.cfg_k            = 8'(k);
        bus.cfg_l            = 8'(l);
        bus.cfg_norm         = 5'(norm);

        ok      = (k != 0) && (2*k + l <= MD) && (norm <= AW - 1);
        accept  = m_run && apply && ok;
        exp_err = m_run && apply && !ok;
        take    = valid && !accept;
        emit    = take && m_run;
        if (accept) begin
            m_k = k; m_l = l; m_norm = norm;
            m_run = 1'b0; m_flush = 0;
            hist0.delete(); hist1.delete();
        end else if (take) begin
            hist0.push_front(d0);
            hist1.push_front(d1);
            while (hist0.size() > 2*m_k + m_l) begin
                void'(hist0.pop_back());
                void'(hist1.pop_back());
            end
            if (emit) begin
                model_out(0, y0, o0);
                model_out(1, y1, o1);
            end else begin
                m_flush++;
                if (m_flush == 2*m_k + m_l) m_run = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        bus.cfg_apply        = 1'b0;
        bus.input_data_valid = 1'b0;
        last0 = int'($signed(bus.output_data[SD-1:0]));
        last1 = int'($signed(bus.output_data[2*SD-1:SD]));
        check("valid",     bus.output_data_valid, emit);
        check("cfg_error", bus.cfg_error, exp_err);
        check("cfg_ready", bus.cfg_ready, m_run);
        if (emit) begin
            check("ch0", last0, y0);
            check("ch1", last1, y1);
            check("ovf", bus.output_overflow, {o1, o0});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  bus.output_data, 0);
        check({tag, "_valid"}, bus.output_data_valid, 0);
        check({tag, "_ovf"},   bus.output_overflow, 0);
        check({tag, "_ready"}, bus.cfg_ready, 0);
        check({tag, "_err"},   bus.cfg_error, 0);
    endtask

    initial begin
        bus.input_data = '0; bus.input_data_valid = 0; bus.cfg_apply = 0;
        bus.cfg_k = '0; bus.cfg_l = '0; bus.cfg_norm = '0;
        model_reset();

        // power-up reset, checked before any clock edge
        #1 reset_n = 1'b0;
        #2 check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // default config: 70 samples of flush, then output on the next sample
        for (int i = 0; i < 70; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        check("ready_after_70", bus.cfg_ready, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("first_out", last0, 0);

        // k=4 l=2 norm=2 step response, both polarities
        cycle(0, 0, 0, 1, 4, 2, 2);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 14; j++) begin
            cycle(1, 1000, -1000, 0, 0, 0, 0);
            check("step_ch0", last0, step035[j]);
            check("step_ch1", last1, -step035[j]);
        end

        // norm=0 with a large step: clamps then returns to zero
        cycle(0, 0, 0, 1, 4, 2, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 14; j++) begin
            cycle(1, 20000, 0, 0, 0, 0, 0);
            if (j == 1) begin
                check("clamp_val", last0, 32767);
                check("clamp_ovf", bus.output_overflow[0], 1);
            end
        end
        check("clamp_tail", last0, 0);

        // rejected configurations leave k=4 l=2 norm=0 in place
        cycle(0, 0, 0, 1, 200, 0, 2);
        check("rej_ready", bus.cfg_ready, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("rej_pulse_len", bus.cfg_error, 0);
        cycle(0, 0, 0, 1, 0, 3, 1);
        cycle(0, 0, 0, 1, 3, 3, 25);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 12; j++) begin
            cycle(1, 1000, 500, 0, 0, 0, 0);
            check("rej_step", last0, 4 * step035[j]);
        end

        // config coincident with a sample: no output, flush of exactly 2k+l
        cycle(1, 111, 222, 1, 3, 1, 1);
        for (int i = 0; i < 6; i++) cycle(1, 100 * i, -50 * i, 0, 0, 0, 0);
        check("flush_6", bus.cfg_ready, 0);
        cycle(0, 0, 0, 1, 9, 9, 9);      // ignored while flushing
        cycle(1, 7, 7, 0, 0, 0, 0);
        check("flush_7", bus.cfg_ready, 1);

        // randomized traffic against the reference
        for (int i = 0; i < 1500; i++) begin
            bit v, a;
            int k, l, nm;
            v = ($urandom_range(0, 9) < 7);
            a = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) k = $urandom_range(100, 150);
            else                           k = $urandom_range(0, 12);
            l  = $urandom_range(0, 10);
            nm = $urandom_range(0, 26);
            if (a && !((k != 0) && (2*k + l <= MD) && (nm <= AW - 1))) v = 1'b0;
            cycle(v, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                  a, k, l, nm);
        end

        // reset mid-step: outputs clear at once, defaults return
        cycle(0, 0, 0, 1, 4, 2, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 20000, 300, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 69; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        check("rst_flush_69", bus.cfg_ready, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("rst_flush_70", bus.cfg_ready, 1);
        for (int i = 0; i < 80; i++) cycle(1, 5000, -5000, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
